// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Latency: WIDTH+1 edges from start to HI/LO write (done the cycle after); MTHI/MTLO write on the start edge.
// Backpressure: start is only taken while busy=0; a start while busy is dropped. Build option: MULDIV_EARLY_OUT_EN.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int CNT_BIT = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_x,
  input  logic [WIDTH-1:0] data_y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;

  state_t               state_q, state_d;
  logic [CNT_BIT-1:0]   cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;  // product / quotient must be negated
  logic                 neg_rem_q, neg_rem_d;  // remainder must be negated
  logic                 dbz_q, dbz_d;          // divide by zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  // Request decode
  logic             accept;
  logic             md_op;
  logic             op_div;
  logic             op_signed;
  logic             x_neg, y_neg;
  logic [WIDTH-1:0] x_mag, y_mag;
  logic             early_out;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign md_op     = !op[2];
  assign op_div    = op[1];
  assign op_signed = !op[0];
  assign x_neg     = op_signed && data_x[WIDTH-1];
  assign y_neg     = op_signed && data_y[WIDTH-1];
  assign x_mag     = x_neg ? -data_x : data_x;
  assign y_mag     = y_neg ? -data_y : data_y;

`ifdef MULDIV_EARLY_OUT_EN
  // A zero operand fully determines the result, so the iterations can be skipped.
  assign early_out = (data_x == '0) || (data_y == '0);
`else
  assign early_out = 1'b0;
`endif

  // One iteration of each algorithm
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_tmp;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, opnd_q} & {(WIDTH+1){acc_q[0]}});
  assign div_tmp  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge   = div_tmp >= {1'b0, opnd_q};
  // The difference always fits in WIDTH bits because the remainder stays below the divisor.
  assign div_diff = div_tmp[WIDTH-1:0] - opnd_q;

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_quo;
  logic [WIDTH-1:0]   fix_rem;

  assign fix_prod = neg_res_q ? -acc_q : acc_q;
  assign fix_quo  = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign fix_rem  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: flush always returns to IDLE from an in-flight op
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && md_op) state_d = early_out ? S_FIX : S_RUN;
      S_RUN: begin
        if (flush)                           state_d = S_IDLE;
        else if (cnt_q == CNT_BIT'(1))       state_d = S_FIX;
      end
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next-state per state
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (md_op) begin
            is_div_d  = op_div;
            neg_res_d = x_neg ^ y_neg;
            neg_rem_d = x_neg;
            dbz_d     = op_div && (data_y == '0);
            cnt_d     = CNT_BIT'(WIDTH);
            opnd_d    = op_div ? y_mag : x_mag;
            if (early_out)
              // Zero product/quotient; the remainder is the dividend itself.
              acc_d = op_div ? {x_mag, {WIDTH{1'b0}}} : '0;
            else
              acc_d = op_div ? {{WIDTH{1'b0}}, x_mag} : {{WIDTH{1'b0}}, y_mag};
          end else if (op == OP_MTHI) begin
            hi_d   = data_x;
            done_d = 1'b1;
          end else if (op == OP_MTLO) begin
            lo_d   = data_x;
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (!flush) begin
          cnt_d = cnt_q - CNT_BIT'(1);
          if (is_div_q)
            acc_d = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                           : {div_tmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          else
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = fix_rem;
            lo_d = dbz_q ? {WIDTH{1'b1}} : fix_quo;
          end else begin
            {hi_d, lo_d} = fix_prod;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed operations, per-cycle comparison against an arithmetic model.
// Latency: checks exact edge counts from start to done.
// Backpressure: exercises start-while-busy, flush and mid-op reset.
module tb_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_Z = 1;
`else
  localparam int LAT_Z = W + 1;
`endif
  localparam int LAT_FULL = W + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start = 1'b0;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] data_x = '0;
  logic [W-1:0] data_y = '0;
  logic         flush = 1'b0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .data_x(data_x), .data_y(data_y), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Arithmetic reference for the four iterative ops: returns {hi, lo}
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p;
    logic [63:0] r;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    r  = '0;
    case (o)
      3'd0: begin p = sx * sy; r = p; end
      3'd1: r = {32'h0, x} * {32'h0, y};
      3'd2: begin
        if (y == 0)                                  r = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == '1)      r = {32'h0, 32'h8000_0000};
        else                                         r = {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 0) r = {x, 32'hFFFF_FFFF};
        else        r = {x % y, x / y};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Transaction-level model: an op completes a fixed number of edges after acceptance
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] nh, nl;
    logic        nb, nd;
    int          nleft;
    logic [63:0] nres;
    if (!rst_n) begin
      m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else begin
      nh = m_hi; nl = m_lo; nb = m_busy; nd = 1'b0; nleft = m_left; nres = m_res;
      if (m_busy) begin
        if (flush) nb = 1'b0;
        else begin
          nleft = nleft - 1;
          if (nleft == 0) begin {nh, nl} = m_res; nb = 1'b0; nd = 1'b1; end
        end
      end else if (start && !flush) begin
        if (op <= 3'd3) begin
          nres  = ref_op(op, data_x, data_y);
          nb    = 1'b1;
          nleft = (LAT_Z == 1 && (data_x == 0 || data_y == 0)) ? 1 : LAT_FULL;
        end else if (op == 3'd4) begin nh = data_x; nd = 1'b1; end
        else if (op == 3'd5) begin nl = data_x; nd = 1'b1; end
      end
      m_hi <= nh; m_lo <= nl; m_busy <= nb; m_done <= nd; m_left <= nleft; m_res <= nres;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
    chk("cyc_done", {31'b0, done}, {31'b0, m_done});
    chk("cyc_hi", hi, m_hi);
    chk("cyc_lo", lo, m_lo);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; data_x = x; data_y = y;
    step();
    start = 1'b0;
  endtask

  // Returns the number of edges after the start edge until done is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input int lat, input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    issue(o, x, y);
    wait_done(n);
    chk({name, "_lat"}, 32'(n), 32'(lat));
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Back-to-back in the done cycle: each run issues right after the previous done
    run("mult_neg3x5", 3'd0, 32'hFFFF_FFFD, 32'd5, LAT_FULL, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run("multu_max",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_FULL, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult_m1m1",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_FULL, 32'h0, 32'h1);
    run("div_neg7by2", 3'd2, 32'hFFFF_FFF9, 32'd2, LAT_FULL, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_ovf",     3'd2, 32'h8000_0000, 32'hFFFF_FFFF, LAT_FULL, 32'h0, 32'h8000_0000);
    run("div_7bym3",   3'd2, 32'd7, 32'hFFFF_FFFD, LAT_FULL, 32'h1, 32'hFFFF_FFFE);
    run("divu_by0",    3'd3, 32'd7, 32'd0, LAT_Z, 32'h7, 32'hFFFF_FFFF);
    run("div_neg_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, LAT_Z, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run("mult_zero",   3'd0, 32'd0, 32'd5, LAT_Z, 32'h0, 32'h0);
    run("divu_big",    3'd3, 32'hFFFF_FFFF, 32'h0001_0000, LAT_FULL, 32'h0000_FFFF, 32'h0000_FFFF);

    // MTHI / MTLO: written on the start edge, done next cycle, never busy
    issue(3'd4, 32'h1234_5678, 32'h0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_done", {31'b0, done}, 32'h1);
    chk("mthi_busy", {31'b0, busy}, 32'h0);
    issue(3'd5, 32'hCAFE_F00D, 32'h0);
    chk("mtlo_lo", lo, 32'hCAFE_F00D);
    chk("mtlo_hi", hi, 32'h1234_5678);
    step();
    chk("mtlo_done_clear", {31'b0, done}, 32'h0);

    // Start while busy is ignored
    issue(3'd3, 32'd100, 32'd7);
    step(); step();
    issue(3'd1, 32'd3, 32'd3);
    wait_done(n);
    chk("ign_lat", 32'(n), 32'(LAT_FULL - 3));
    chk("ign_hi", hi, 32'd2);
    chk("ign_lo", lo, 32'd14);
    repeat (40) step();
    chk("ign_no_second_hi", hi, 32'd2);

    // Flush at edge 10 of a DIVU
    issue(3'd3, 32'd100, 32'd7);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) n++;
      step();
    end
    chk("flush_no_done", 32'(n), 32'h0);
    chk("flush_hi", hi, 32'd2);
    chk("flush_lo", lo, 32'd14);

    // Flush and start together in IDLE: request dropped
    flush = 1'b1;
    issue(3'd4, 32'hDEAD_BEEF, 32'h0);
    flush = 1'b0;
    chk("flushstart_hi", hi, 32'd2);
    chk("flushstart_done", {31'b0, done}, 32'h0);
    issue(3'd0, 32'd9, 32'd9);
    chk("flushstart_idle_ok", {31'b0, busy}, 32'h1);
    wait_done(n);
    chk("after_flush_lo", lo, 32'd81);

    // Reserved op: no effect, no done
    issue(3'd6, 32'h5555_5555, 32'h1);
    chk("rsv_busy", {31'b0, busy}, 32'h0);
    chk("rsv_done", {31'b0, done}, 32'h0);
    chk("rsv_lo", lo, 32'd81);

    // Reset mid-operation
    issue(3'd3, 32'd100, 32'd7);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_done", {31'b0, done}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    run("post_rst", 3'd3, 32'd100, 32'd7, LAT_FULL, 32'd2, 32'd14);
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
